// File: rtl/lfsr_sched_if.sv
// lfsr_sched_if: requester handshake and LFSR control bundle for lfsr_sched
interface lfsr_sched_if #(parameter int N = 4);
  logic en;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_seed;
  logic [15:0] rnd_data;
  logic [15:0] gnt_cnt;
  logic lfsr_step;
  logic rnd_valid;
  modport master (output en, req, lfsr_q, input gnt, lfsr_seed, rnd_data, gnt_cnt, lfsr_step, rnd_valid);
  modport slave (input en, req, lfsr_q, output gnt, lfsr_seed, rnd_data, gnt_cnt, lfsr_step, rnd_valid);
endinterface

// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin sharing of one LFSR among N requesters with warm-up and per-grant decorrelation steps
module lfsr_sched #(
  parameter int N = 4,
  parameter int STEPS = 16,
  parameter int WARMUP = 32,
  parameter logic [15:0] SEED = 16'h0001
) (
  input logic clk,
  input logic rst,
  lfsr_sched_if.slave bus
);
  localparam int W = $clog2(N);
  typedef enum logic [1:0] {WARM, IDLE, ADV, GRANT} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [W-1:0] winner, ptr, sel;
  assign bus.lfsr_seed = SEED;
  assign bus.rnd_data = bus.rnd_valid ? bus.lfsr_q : '0;
  // descending scan so the lowest offset from ptr+1 wins
  always_comb begin
    logic [W-1:0] idx;
    sel = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (bus.req[idx]) sel = idx;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= (WARMUP > 0) ? WARM : IDLE;
      cnt <= 16'(WARMUP);
      ptr <= W'(N - 1);
      winner <= '0;
      bus.lfsr_step <= (WARMUP > 0);
      bus.gnt <= '0;
      bus.rnd_valid <= 1'b0;
      bus.gnt_cnt <= '0;
    end else
      case (state)
        WARM: begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            state <= IDLE;
            bus.lfsr_step <= 1'b0;
          end
        end
        IDLE:
          if (bus.en && |bus.req) begin
            winner <= sel;
            cnt <= 16'(STEPS);
            bus.lfsr_step <= 1'b1;
            state <= ADV;
          end
        ADV: begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            state <= GRANT;
            bus.lfsr_step <= 1'b0;
            bus.gnt <= N'(1) << winner;
            bus.rnd_valid <= 1'b1;
          end
        end
        default: begin
          bus.gnt <= '0;
          bus.rnd_valid <= 1'b0;
          ptr <= winner;
          bus.gnt_cnt <= bus.gnt_cnt + 16'd1;
          state <= IDLE;
        end
      endcase
endmodule

// File: doc/lfsr_sched.md
# lfsr_sched

Round-robin scheduler that shares the team's single 16-bit LFSR random-word generator among N requesters. After reset it runs a warm-up burst of LFSR steps. For each grant it advances the LFSR a programmable number of steps to decorrelate successive words, then delivers the current LFSR word to exactly one requester for one cycle. It sits between the LFSR instance (driving its step enable and seed) and the blocks that consume random words.

## Interface
- N, 4: number of requesters (2..16).
- STEPS, 16: LFSR steps per grant (>=1).
- WARMUP, 32: LFSR steps after reset before the first arbitration (>=0).
- SEED, 16'h0001: constant seed presented to the LFSR load input.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset; also drives LFSR reset (LFSR loads seed).
- en  in  1  arbitration enable; low blocks new arbitration only.
- req  in  N  request per requester, level, held until granted.
- lfsr_q  in  16  current LFSR state.
- lfsr_step  out  1  LFSR advance enable.
- lfsr_seed  out  16  constant SEED.
- gnt  out  N  one-hot grant, one-cycle pulse.
- rnd_valid  out  1  high in the grant cycle.
- rnd_data  out  16  random word, valid when rnd_valid.
- gnt_cnt  out  16  total grants issued, wraps 0xFFFF->0.

## Operation
- LFSR model: next = {q[14:0], fb}, where fb = ~(q[15]^q[14]^q[12]^q[3]). It advances only when lfsr_step=1.
- States: WARM, IDLE, ADV, GRANT. Internal registers: step counter, latched winner, round-robin pointer ptr (reset N-1).
- WARM:
  - lfsr_step=1 for WARMUP cycles, then go to IDLE.
  - With WARMUP=0, reset exits directly to IDLE.
  - en is ignored in WARM.
- IDLE:
  - If en=1 and req!=0, latch as winner the first set req bit scanning from index ptr+1 upward, modulo N.
  - Then go to ADV with the counter loaded to STEPS.
  - Otherwise stay in IDLE.
- ADV:
  - lfsr_step=1 every cycle; decrement the counter; after STEPS cycles go to GRANT.
  - req is not re-sampled: a requester dropping req during ADV still receives the grant.
  - en has no effect once arbitration has happened.
- GRANT (one cycle):
  - gnt[winner]=1, rnd_valid=1, rnd_data=lfsr_q (combinational pass-through), lfsr_step=0.
  - Next edge: ptr<=winner, gnt_cnt+=1, state<=IDLE.
- Outside GRANT: gnt=0, rnd_valid=0, rnd_data=0.
- Exactly one gnt bit is set only in GRANT. lfsr_step is never high in IDLE or GRANT.
- A req bit set at an index >= N cannot occur (width N). Simultaneous requests are resolved only by ptr order.

## Timing
- Reset values: state WARM (or IDLE if WARMUP=0); lfsr_step=1 if WARMUP>0, else 0; gnt=0, rnd_valid=0, rnd_data=0, gnt_cnt=0, ptr=N-1.
- Reset mid-operation: all state discarded immediately; no grant issued; warm-up restarts after release.
- Latency: req seen high in an IDLE cycle -> gnt pulse STEPS+1 cycles later.
- Throughput: one grant per STEPS+2 cycles under continuous requests, because an IDLE cycle always separates consecutive grants.
- The word delivered reflects exactly WARMUP + k*STEPS LFSR steps from the seed at grant k (k from 1).

## Test plan
All scenarios use N=4, WARMUP=2, STEPS=1, SEED=0x0001, with the team's LFSR instance driven by the block.
- Reset, req=0: lfsr_step high for exactly 2 cycles after release, lfsr_q=0x0007, then idle; gnt=0, gnt_cnt=0 indefinitely.
- After warm-up, req=4'b0001: gnt=0001 with rnd_data=0x000F exactly 2 cycles after the IDLE sample; gnt_cnt=1.
- From reset, req=4'b1111 held:
  - gnt sequence 0001, 0010, 0100, 1000, 0001, each 3 cycles apart.
  - rnd_data 0x000F, 0x001E, 0x003C, 0x0078, 0x00F0.
- req=4'b1010 with ptr=1 (after a grant to requester 1): next grant goes to requester 3, then requester 1.
- en=0 with req=4'b0100: no lfsr_step, no gnt for 20 cycles. Raise en: gnt=0100 2 cycles after the first IDLE cycle with en=1.
- Assert rst during ADV: gnt never pulses, outputs 0, gnt_cnt=0. After release, warm-up repeats and lfsr_q returns to 0x0007.
- req dropped to 0 during ADV: grant still issued to the latched winner.
